// File: rtl/bsync_align_sequencer.sv
// bsync_align_sequencer
//   Sequences the BSYNC generator through reset, arming, calibration and
//   alignment verification, then holds it locked. Failed attempts (timeout or
//   misalignment) are retried up to MAX_RETRIES times before giving up.
//
// Build option:
//   BSYNC_SEQ_AUTO_RELOCK_EN - when defined, an alignment error while LOCKED
//   re-enters the retry path; otherwise it goes straight to FAIL.
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   start                     one-cycle sequence request (idle/locked/fail only)
//   abort                     level, forces IDLE; has priority over start
//   gen_ready/gen_captured    generator progress flags
//   gen_alignment_error       generator misalignment flag
//   gen_state[2:0]            generator FSM state (3 = BSYNC_GEN)
//   gen_delay[4:0]            generator measured delay
//   gen_ratio[15:0]           generator measured ratio
//   gen_rstn                  generator reset, active-low
//   gen_direction             generator direction/arm
//   gen_disable_internal      generator internal BSYNC disable
//   busy, locked, fail        status flags
//   retry_count[3:0]          retries consumed in the current sequence
//   lock_delay, lock_ratio    generator results latched at lock
//   seq_state[2:0]            registered sequencer state
module bsync_align_sequencer #(
  parameter int unsigned RESET_CYCLES   = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned SETTLE_CYCLES  = 256,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        abort,
  input  logic        gen_ready,
  input  logic        gen_captured,
  input  logic        gen_alignment_error,
  input  logic [2:0]  gen_state,
  input  logic [4:0]  gen_delay,
  input  logic [15:0] gen_ratio,
  output logic        gen_rstn,
  output logic        gen_direction,
  output logic        gen_disable_internal,
  output logic        busy,
  output logic        locked,
  output logic        fail,
  output logic [3:0]  retry_count,
  output logic [4:0]  lock_delay,
  output logic [15:0] lock_ratio,
  output logic [2:0]  seq_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RESET  = 3'd1,
    ARM    = 3'd2,
    CALIB  = 3'd3,
    VERIFY = 3'd4,
    LOCKED = 3'd5,
    RETRY  = 3'd6,
    FAIL   = 3'd7
  } state_t;

  localparam int unsigned RST_W = (RESET_CYCLES  > 1) ? $clog2(RESET_CYCLES + 1)  : 1;
  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int unsigned TMO_W = 20;

  // Each counter holds (cycles already spent - 1) on the cycle it fires, so the
  // transition lands on the edge where the count would reach its limit.
  localparam logic [RST_W-1:0] RST_LAST   = RST_W'(RESET_CYCLES - 1);
  localparam logic [SET_W-1:0] SET_LAST   = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX  = 4'(MAX_RETRIES);

  state_t           state_q, state_d;
  logic [RST_W-1:0] rst_cnt;
  logic [SET_W-1:0] settle_cnt;
  logic [TMO_W-1:0] tmo_cnt;

  logic tmo_hit;
  logic settle_ok;
  logic rstn_d, dir_d, dis_d, busy_d, locked_d, fail_d;

  assign tmo_hit   = (tmo_cnt == TMO_LAST);
  assign settle_ok = (gen_state == 3'd3) && !gen_alignment_error;
  assign seq_state = state_q;

  // State register and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q              <= IDLE;
      gen_rstn             <= 1'b0;
      gen_direction        <= 1'b0;
      gen_disable_internal <= 1'b1;
      busy                 <= 1'b0;
      locked               <= 1'b0;
      fail                 <= 1'b0;
    end else begin
      state_q              <= state_d;
      gen_rstn             <= rstn_d;
      gen_direction        <= dir_d;
      gen_disable_internal <= dis_d;
      busy                 <= busy_d;
      locked               <= locked_d;
      fail                 <= fail_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:   if (start) state_d = RESET;
        RESET:  if (rst_cnt == RST_LAST) state_d = ARM;
        ARM: begin
          if (tmo_hit)           state_d = RETRY;
          else if (gen_captured) state_d = CALIB;
        end
        CALIB: begin
          if (tmo_hit)        state_d = RETRY;
          else if (gen_ready) state_d = VERIFY;
        end
        VERIFY: begin
          if (tmo_hit || gen_alignment_error)       state_d = RETRY;
          else if (settle_ok && settle_cnt == SET_LAST) state_d = LOCKED;
        end
        LOCKED: begin
          if (start) begin
            state_d = RESET;
          end else if (gen_alignment_error) begin
`ifdef BSYNC_SEQ_AUTO_RELOCK_EN
            state_d = RETRY;
`else
            state_d = FAIL;
`endif
          end
        end
        RETRY:  state_d = (retry_count >= RETRY_MAX) ? FAIL : RESET;
        FAIL:   if (start) state_d = RESET;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output decode from the next state so outputs register alongside state
  always_comb begin
    rstn_d   = 1'b0;
    dir_d    = 1'b0;
    dis_d    = 1'b1;
    busy_d   = 1'b0;
    locked_d = 1'b0;
    fail_d   = 1'b0;
    unique case (state_d)
      RESET: busy_d = 1'b1;
      ARM, CALIB: begin
        rstn_d = 1'b1;
        dir_d  = 1'b1;
        busy_d = 1'b1;
      end
      VERIFY: begin
        rstn_d = 1'b1;
        dir_d  = 1'b1;
        dis_d  = 1'b0;
        busy_d = 1'b1;
      end
      LOCKED: begin
        rstn_d   = 1'b1;
        dir_d    = 1'b1;
        dis_d    = 1'b0;
        locked_d = 1'b1;
      end
      // Generator stays out of reset here so the following RESET pulse is
      // exactly RESET_CYCLES long.
      RETRY: begin
        rstn_d = 1'b1;
        busy_d = 1'b1;
      end
      FAIL:    fail_d = 1'b1;
      default: ;
    endcase
  end

  // Counters, retry bookkeeping and lock capture
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rst_cnt     <= '0;
      settle_cnt  <= '0;
      tmo_cnt     <= '0;
      retry_count <= '0;
      lock_delay  <= '0;
      lock_ratio  <= '0;
    end else begin
      if (state_q == RESET && state_d == RESET) rst_cnt <= rst_cnt + 1'b1;
      else                                      rst_cnt <= '0;

      if (state_q == VERIFY && state_d == VERIFY && settle_ok) settle_cnt <= settle_cnt + 1'b1;
      else                                                     settle_cnt <= '0;

      // Shared timeout: restarts on every entry into ARM, CALIB or VERIFY.
      if (state_d == state_q && (state_q == ARM || state_q == CALIB || state_q == VERIFY))
        tmo_cnt <= tmo_cnt + 1'b1;
      else
        tmo_cnt <= '0;

      if (state_d == RESET) begin
        if (state_q == RETRY)                                          retry_count <= retry_count + 1'b1;
        else if (state_q == IDLE || state_q == LOCKED || state_q == FAIL) retry_count <= '0;
      end

      if (state_q == VERIFY && state_d == LOCKED) begin
        lock_delay <= gen_delay;
        lock_ratio <= gen_ratio;
      end
    end
  end

endmodule
